// File: rtl/cpu_pkg.sv
// Shared CPU definitions: micro-op encodings, data cache geometry, LSU states.
// Latency: none (constants and types only).
// Backpressure: none.
package cpu_pkg;

   // Micro-op encodings shared by decode, the LSU and the data cache
   localparam logic [4:0] NOP_UOP = 5'b00000;
   localparam logic [4:0] STR_UOP = 5'b01001;
   localparam logic [4:0] LDR_UOP = 5'b01010;

   // Data cache holds DCACHE_DEPTH 32-bit words, word-addressed
   localparam int unsigned DCACHE_DEPTH = 32;

   // Destination-register tag width
   localparam int unsigned RD_W = 4;

   typedef enum logic [2:0] {
      LSU_IDLE       = 3'd0,
      LSU_ST_ISSUE   = 3'd1,
      LSU_LD_ISSUE   = 3'd2,
      LSU_LD_CAPTURE = 3'd3,
      LSU_RESP       = 3'd4
   } lsu_state_t;

   // True for the two micro-ops that touch memory
   function automatic logic is_mem_uop(input logic [4:0] uop);
      return (uop == STR_UOP) || (uop == LDR_UOP);
   endfunction

endpackage

// File: rtl/lsu_stage.sv
// Load/store stage: one memory uop at a time from execute to the data cache, load result / fault to writeback.
// Latency: store busy 1 cycle; load response 2 cycles after accept; out-of-range fault response same edge as accept.
// Backpressure: ex_ready only in IDLE; response held stable in RESP until wb_ready, blocking further accepts.
module lsu_stage
   import cpu_pkg::*;
(
   input  logic            clock,
   input  logic            reset_n,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [4:0]      ex_uop,
   input  logic [31:0]     ex_addr,
   input  logic [31:0]     ex_data,
   input  logic [RD_W-1:0] ex_rd,
   output logic [4:0]      dc_uop,
   output logic [31:0]     dc_addr,
   output logic [31:0]     dc_data,
   input  logic [31:0]     dc_rdata,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RD_W-1:0] wb_rd,
   output logic [31:0]     wb_data,
   output logic            wb_fault
);

   lsu_state_t      state_q,    state_d;
   logic [4:0]      dc_uop_q,   dc_uop_d;
   logic [31:0]     dc_addr_q,  dc_addr_d;
   logic [31:0]     dc_data_q,  dc_data_d;
   logic            wb_valid_q, wb_valid_d;
   logic [RD_W-1:0] wb_rd_q,    wb_rd_d;
   logic [31:0]     wb_data_q,  wb_data_d;
   logic            wb_fault_q, wb_fault_d;

   logic accept;
   logic addr_ok;

   // Next-state and output-register logic for the LSU sequencer
   always_comb begin
      state_d    = state_q;
      dc_uop_d   = dc_uop_q;
      dc_addr_d  = dc_addr_q;
      dc_data_d  = dc_data_q;
      wb_valid_d = wb_valid_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      wb_fault_d = wb_fault_q;

      accept  = ex_valid && (state_q == LSU_IDLE);
      // Full-width compare so high address bits cannot alias into the cache
      addr_ok = (ex_addr < 32'(DCACHE_DEPTH));

      unique case (state_q)
         LSU_IDLE: begin
            // Non-memory uops are consumed and dropped without leaving IDLE
            if (accept && is_mem_uop(ex_uop)) begin
               if (!addr_ok) begin
                  // Out-of-range: answer immediately, cache never sees the op
                  wb_data_d  = 32'd0;
                  wb_fault_d = 1'b1;
                  wb_rd_d    = ex_rd;
                  wb_valid_d = 1'b1;
                  state_d    = LSU_RESP;
               end else if (ex_uop == STR_UOP) begin
                  dc_uop_d  = STR_UOP;
                  dc_addr_d = ex_addr;
                  dc_data_d = ex_data;
                  state_d   = LSU_ST_ISSUE;
               end else begin
                  dc_uop_d  = LDR_UOP;
                  dc_addr_d = ex_addr;
                  wb_rd_d   = ex_rd;
                  state_d   = LSU_LD_ISSUE;
               end
            end
         end
         LSU_ST_ISSUE: begin
            dc_uop_d = NOP_UOP;
            state_d  = LSU_IDLE;
         end
         LSU_LD_ISSUE: begin
            // Cache registers the read at the end of this cycle
            dc_uop_d = NOP_UOP;
            state_d  = LSU_LD_CAPTURE;
         end
         LSU_LD_CAPTURE: begin
            wb_data_d  = dc_rdata;
            wb_fault_d = 1'b0;
            wb_valid_d = 1'b1;
            state_d    = LSU_RESP;
         end
         LSU_RESP: begin
            if (wb_ready) begin
               wb_valid_d = 1'b0;
               state_d    = LSU_IDLE;
            end
         end
         default: begin
            dc_uop_d   = NOP_UOP;
            wb_valid_d = 1'b0;
            state_d    = LSU_IDLE;
         end
      endcase
   end

   // State and output registers; async reset drops any in-flight op at once
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= LSU_IDLE;
         dc_uop_q   <= NOP_UOP;
         dc_addr_q  <= 32'd0;
         dc_data_q  <= 32'd0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= 32'd0;
         wb_fault_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dc_uop_q   <= dc_uop_d;
         dc_addr_q  <= dc_addr_d;
         dc_data_q  <= dc_data_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         wb_fault_q <= wb_fault_d;
      end
   end

   assign ex_ready = (state_q == LSU_IDLE);
   assign dc_uop   = dc_uop_q;
   assign dc_addr  = dc_addr_q;
   assign dc_data  = dc_data_q;
   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign wb_fault = wb_fault_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage with a behavioural data cache (negedge write, registered read).
// Latency: checks 2-cycle load response, 0-cycle fault response, 1-cycle store turnaround.
// Backpressure: exercises wb_ready held low and ex_valid held high.
module tb_lsu_stage;
   import cpu_pkg::*;

   logic            clock;
   logic            reset_n;
   logic            ex_valid;
   logic            ex_ready;
   logic [4:0]      ex_uop;
   logic [31:0]     ex_addr;
   logic [31:0]     ex_data;
   logic [RD_W-1:0] ex_rd;
   logic [4:0]      dc_uop;
   logic [31:0]     dc_addr;
   logic [31:0]     dc_data;
   logic [31:0]     dc_rdata;
   logic            wb_valid;
   logic            wb_ready;
   logic [RD_W-1:0] wb_rd;
   logic [31:0]     wb_data;
   logic            wb_fault;

   lsu_stage dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .ex_valid (ex_valid),
      .ex_ready (ex_ready),
      .ex_uop   (ex_uop),
      .ex_addr  (ex_addr),
      .ex_data  (ex_data),
      .ex_rd    (ex_rd),
      .dc_uop   (dc_uop),
      .dc_addr  (dc_addr),
      .dc_data  (dc_data),
      .dc_rdata (dc_rdata),
      .wb_valid (wb_valid),
      .wb_ready (wb_ready),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .wb_fault (wb_fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Data cache model: writes on the falling edge, read registered on the next rising edge
   logic [31:0] mem [DCACHE_DEPTH];
   logic        ld_pend = 1'b0;
   logic [31:0] ld_val  = 32'd0;
   int          n_wr = 0;
   int          n_rd = 0;
   initial begin
      for (int i = 0; i < int'(DCACHE_DEPTH); i++) mem[i] = 32'd0;
      dc_rdata = 32'd0;
   end
   always @(negedge clock) begin
      if (dc_uop == STR_UOP) begin
         mem[dc_addr[4:0]] <= dc_data;
         n_wr <= n_wr + 1;
      end
      if (dc_uop == LDR_UOP) begin
         ld_val  <= mem[dc_addr[4:0]];
         ld_pend <= 1'b1;
         n_rd    <= n_rd + 1;
      end
   end
   always @(posedge clock) begin
      if (ld_pend) begin
         dc_rdata <= ld_val;
         ld_pend  <= 1'b0;
      end
   end

   int checks = 0;
   int errors = 0;
   int acc_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Present a uop and return #1 after the accepting edge, with ex_valid dropped
   task automatic issue(input logic [4:0] u, input logic [31:0] a, input logic [31:0] d,
                        input logic [RD_W-1:0] r);
      int n;
      ex_uop = u; ex_addr = a; ex_data = d; ex_rd = r; ex_valid = 1'b1;
      n = 0;
      while (!ex_ready && n < 50) begin
         @(posedge clock); #1; n++;
      end
      if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
      @(posedge clock); #1;
      acc_cyc = cyc;
      ex_valid = 1'b0;
   endtask

   task automatic wait_wb(output int lat);
      int n;
      n = 0;
      while (!wb_valid && n < 20) begin
         @(posedge clock); #1; n++;
      end
      if (!wb_valid) chk("wb_timeout", 32'(wb_valid), 32'd1);
      lat = cyc - acc_cyc;
   endtask

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE_0000 | (32'(i) * 32'h0000_0111);
   endfunction

   typedef struct {
      logic [4:0]      uop;
      logic [31:0]     addr;
      logic [31:0]     data;
      logic [RD_W-1:0] rd;
      bit              resp;
      logic            fault;
      logic [31:0]     exp_data;
      int              exp_lat;
      int              exp_wr;
      int              exp_rd;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int lat, w0, r0, t0;
      logic saw;

      vecs[0] = '{STR_UOP, 32'd5,          32'hDEADBEEF, 4'd0,  1'b0, 1'b0, 32'd0,         0, 1, 0};
      vecs[1] = '{LDR_UOP, 32'd5,          32'd0,        4'd3,  1'b1, 1'b0, 32'hDEADBEEF,  2, 0, 1};
      vecs[2] = '{LDR_UOP, 32'd32,         32'd0,        4'd7,  1'b1, 1'b1, 32'd0,         0, 0, 0};
      vecs[3] = '{STR_UOP, 32'hFFFF_FFFF,  32'h12345678, 4'd9,  1'b1, 1'b1, 32'd0,         0, 0, 0};
      vecs[4] = '{LDR_UOP, 32'h8000_0000,  32'd0,        4'd12, 1'b1, 1'b1, 32'd0,         0, 0, 0};
      vecs[5] = '{NOP_UOP, 32'd1,          32'h11111111, 4'd1,  1'b0, 1'b0, 32'd0,         0, 0, 0};
      vecs[6] = '{5'b01011, 32'd2,         32'h22222222, 4'd2,  1'b0, 1'b0, 32'd0,         0, 0, 0};
      vecs[7] = '{STR_UOP, 32'd31,         32'hCAFEF00D, 4'd0,  1'b0, 1'b0, 32'd0,         0, 1, 0};
      vecs[8] = '{LDR_UOP, 32'd31,         32'd0,        4'd15, 1'b1, 1'b0, 32'hCAFEF00D,  2, 0, 1};
      vecs[9] = '{LDR_UOP, 32'd0,          32'd0,        4'd1,  1'b1, 1'b0, 32'd0,         2, 0, 1};

      reset_n = 1'b0; ex_valid = 1'b0; ex_uop = NOP_UOP; ex_addr = 32'd0;
      ex_data = 32'd0; ex_rd = '0; wb_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_dc_uop",   32'(dc_uop),   32'(NOP_UOP));
      chk("rst_dc_addr",  dc_addr,       32'd0);
      chk("rst_dc_data",  dc_data,       32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_rd",    32'(wb_rd),    32'd0);
      chk("rst_wb_data",  wb_data,       32'd0);
      chk("rst_wb_fault", 32'(wb_fault), 32'd0);
      chk("rst_ex_ready", 32'(ex_ready), 32'd1);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Table-driven single operations
      for (int i = 0; i < 10; i++) begin
         w0 = n_wr; r0 = n_rd;
         issue(vecs[i].uop, vecs[i].addr, vecs[i].data, vecs[i].rd);
         if (vecs[i].resp) begin
            wait_wb(lat);
            chk($sformatf("v%0d_lat", i),   32'(lat),      32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_data", i),  wb_data,       vecs[i].exp_data);
            chk($sformatf("v%0d_rd", i),    32'(wb_rd),    32'(vecs[i].rd));
            chk($sformatf("v%0d_fault", i), 32'(wb_fault), 32'(vecs[i].fault));
            @(posedge clock); #1;
            chk($sformatf("v%0d_consumed", i), 32'(wb_valid), 32'd0);
         end else begin
            chk($sformatf("v%0d_ready", i), 32'(ex_ready), (vecs[i].uop == STR_UOP) ? 32'd0 : 32'd1);
            saw = 1'b0;
            repeat (3) begin
               @(posedge clock); #1;
               if (wb_valid) saw = 1'b1;
            end
            chk($sformatf("v%0d_noresp", i), 32'(saw), 32'd0);
         end
         chk($sformatf("v%0d_wr", i), 32'(n_wr - w0), 32'(vecs[i].exp_wr));
         chk($sformatf("v%0d_rdcnt", i), 32'(n_rd - r0), 32'(vecs[i].exp_rd));
      end

      // Back-to-back stores with ex_valid held high: one every two cycles
      ex_uop = STR_UOP; ex_valid = 1'b1; t0 = cyc;
      for (int i = 0; i < 32; i++) begin
         ex_addr = 32'(i); ex_data = pat(i);
         chk($sformatf("b2b%0d_ready_hi", i), 32'(ex_ready), 32'd1);
         @(posedge clock); #1;
         chk($sformatf("b2b%0d_ready_lo", i), 32'(ex_ready), 32'd0);
         @(posedge clock); #1;
      end
      ex_valid = 1'b0;
      chk("b2b_cycles", 32'(cyc - t0), 32'd64);
      for (int i = 0; i < 32; i++) begin
         issue(LDR_UOP, 32'(i), 32'd0, RD_W'(i));
         wait_wb(lat);
         chk($sformatf("rb%0d_data", i), wb_data, pat(i));
         @(posedge clock); #1;
      end

      // Writeback stall: response frozen, no new op accepted
      wb_ready = 1'b0;
      issue(LDR_UOP, 32'd7, 32'd0, 4'd4);
      wait_wb(lat);
      chk("hold_lat", 32'(lat), 32'd2);
      ex_uop = STR_UOP; ex_addr = 32'd8; ex_data = 32'h0BADF00D; ex_valid = 1'b1;
      w0 = n_wr;
      for (int k = 0; k < 5; k++) begin
         @(posedge clock); #1;
         chk($sformatf("hold%0d_valid", k), 32'(wb_valid), 32'd1);
         chk($sformatf("hold%0d_data", k),  wb_data,       pat(7));
         chk($sformatf("hold%0d_rd", k),    32'(wb_rd),    32'd4);
         chk($sformatf("hold%0d_ready", k), 32'(ex_ready), 32'd0);
      end
      wb_ready = 1'b1;
      @(posedge clock); #1;
      ex_valid = 1'b0;
      chk("hold_release_valid", 32'(wb_valid), 32'd0);
      chk("hold_release_idle",  32'(ex_ready), 32'd1);
      chk("hold_no_store",      32'(n_wr - w0), 32'd0);
      @(posedge clock); #1;

      // Reset while a load response is pending
      wb_ready = 1'b0;
      issue(LDR_UOP, 32'd3, 32'd0, 4'd2);
      wait_wb(lat);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_resp_valid", 32'(wb_valid), 32'd0);
      chk("rst_resp_rd",    32'(wb_rd),    32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1; wb_ready = 1'b1;
      @(posedge clock); #1;

      // Reset during ST_ISSUE, before the cache's falling-edge write
      w0 = n_wr;
      issue(STR_UOP, 32'd10, 32'hA5A5A5A5, 4'd0);
      chk("st_issue_uop", 32'(dc_uop), 32'(STR_UOP));
      #1 reset_n = 1'b0;
      #1;
      chk("rst_st_dc_uop",  32'(dc_uop),   32'(NOP_UOP));
      chk("rst_st_dc_addr", dc_addr,       32'd0);
      chk("rst_st_dc_data", dc_data,       32'd0);
      chk("rst_st_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_st_ready",   32'(ex_ready), 32'd1);
      @(posedge clock); #1;
      reset_n = 1'b1;
      chk("rst_st_no_write", 32'(n_wr - w0), 32'd0);
      issue(LDR_UOP, 32'd10, 32'd0, 4'd6);
      wait_wb(lat);
      chk("rst_st_word_kept", wb_data, pat(10));
      chk("rst_st_rd",        32'(wb_rd), 32'd6);
      @(posedge clock); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
